mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequences a single-port, fixed-latency SRAM shared by the instruction-fetch stage and the MEM stage of the ARM pipeline. Accepts at most one access at a time, chooses the winner when both stages request, drives the SRAM pins for a configurable number of wait cycles, and returns a one-cycle ready pulse with registered read data. Produces the pipeline stall signals that freeze the requesting stages until their access completes. Sits between the pipeline registers and the external SRAM, driven by the memread/memwrite flags decoded by the controller.

## Interface
- ADDR_W, 32, address width for both ports and the SRAM.
- DATA_W, 32, data width.
- WAIT_CYCLES, 2, extra SRAM wait cycles per access (0..15); ACCESS lasts WAIT_CYCLES+1 cycles.

- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_rdata  out  DATA_W  fetched word; valid in the if_ready cycle, held until the next fetch completes.
- if_ready  out  1  one-cycle completion pulse for fetch.
- dm_read, dm_write  in  1 each  MEM-stage read/write request; held until dm_ready.
- dm_addr, dm_wdata  in  ADDR_W, DATA_W  MEM-stage address/write data.
- dm_rdata  out  DATA_W  load data; valid in the dm_ready cycle, held until the next load completes.
- dm_ready  out  1  one-cycle completion pulse for MEM stage.
- if_stall  out  1  combinational: if_req & ~if_ready.
- dm_stall  out  1  combinational: (dm_read|dm_write) & ~dm_ready.
- sram_cs, sram_we, sram_oe  out  1 each  SRAM chip select, write enable, output enable.
- sram_addr, sram_wdata  out  ADDR_W, DATA_W  SRAM address/write data.
- sram_rdata  in  DATA_W  SRAM read data; valid at the last ACCESS cycle.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any request pending, latch winner (owner bit, addr, wdata, op) and go to ACCESS; else stay.
- Priority: MEM-stage wins over fetch when both pending (see Configuration).
- dm_read and dm_write both high: treated as write.
- ACCESS: sram_cs=1; sram_addr/sram_wdata from latched values; sram_we=1 for writes, sram_oe=1 for reads; wait counter loads WAIT_CYCLES on entry, decrements each cycle; at 0 capture sram_rdata (reads only) into the owner's rdata register and go to DONE.
- DONE: pulse owner's ready for exactly one cycle; all SRAM controls low; return to IDLE.
- Requester must drop or change its request in the cycle after ready; IDLE re-samples then, so the request held during DONE is never re-serviced.
- Requests arriving during ACCESS/DONE wait; no preemption.
- Writes leave both rdata registers unchanged.

## Timing
- Reset (async assert): state IDLE, counter 0, owner fetch, all outputs 0 (rdata registers, ready pulses, SRAM controls, addr, wdata).
- Latency, request visible in IDLE at cycle 0: ACCESS cycles 1..WAIT_CYCLES+1, ready at cycle WAIT_CYCLES+2 (4 with default).
- Throughput: one access per WAIT_CYCLES+3 cycles.
- Reset mid-ACCESS: SRAM controls drop immediately; no ready pulse is ever issued for the aborted access.
- WAIT_CYCLES=0: ACCESS is one cycle.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN defined: when both pending in IDLE, winner is the port not served last (last-served bit resets to fetch, so MEM wins the first tie).
- Undefined: fixed MEM-stage priority; fetch can be starved by continuous MEM traffic.

## Test plan
- Single fetch, if_addr=0x0000_0010, sram_rdata=0xE3A0_1005 -> sram_cs/oe high cycles 1-3, if_ready and if_rdata=0xE3A0_1005 at cycle 4, dm_ready stays 0.
- Store dm_write, dm_addr=0x400, dm_wdata=0xDEAD_BEEF -> sram_we=1 with that addr/data cycles 1-3, dm_ready at cycle 4, dm_rdata unchanged, dm_stall high cycles 0-3.
- Simultaneous if_req and dm_read -> MEM served first (ready at 4); fetch starts next IDLE, if_ready at 9; if_stall high throughout until 9.
- Same as above, 3 back-to-back, with MEM_ARB_ROUND_ROBIN_EN -> grant order MEM, fetch, MEM; without -> MEM on every tie while MEM keeps requesting.
- rst low during cycle 2 of a load -> all outputs 0 at once, no dm_ready; after release, reissued load completes normally in 4 cycles.
- WAIT_CYCLES=0, dm_read and dm_write both high -> write performed, dm_ready at cycle 2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port SRAM sequencer shared by instruction fetch and the MEM stage.
// Optional MEM_ARB_ROUND_ROBIN_EN: alternate winner on ties (default: MEM priority).
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              sram_cs,
  output logic              sram_we,
  output logic              sram_oe,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               owner, owner_nx;     // 1: MEM stage, 0: fetch; doubles as last-served
  logic               is_write, write_nx;
  logic               cs_nx, we_nx, oe_nx;
  logic [ADDR_W-1:0]  addr_nx;
  logic [DATA_W-1:0]  wdata_nx;
  logic [DATA_W-1:0]  if_rdata_nx, dm_rdata_nx;
  logic               if_ready_nx, dm_ready_nx;
  logic               dm_req;
  logic               grant_dm;

  assign dm_req   = dm_read | dm_write;
  assign if_stall = if_req & ~if_ready;
  assign dm_stall = dm_req & ~dm_ready;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // On a tie, serve the port that did not win last time.
  assign grant_dm = dm_req & (~if_req | ~owner);
`else
  assign grant_dm = dm_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= 1'b0;
      is_write   <= 1'b0;
      sram_cs    <= 1'b0;
      sram_we    <= 1'b0;
      sram_oe    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      owner      <= owner_nx;
      is_write   <= write_nx;
      sram_cs    <= cs_nx;
      sram_we    <= we_nx;
      sram_oe    <= oe_nx;
      sram_addr  <= addr_nx;
      sram_wdata <= wdata_nx;
      if_rdata   <= if_rdata_nx;
      dm_rdata   <= dm_rdata_nx;
      if_ready   <= if_ready_nx;
      dm_ready   <= dm_ready_nx;
    end
  end

  // SRAM pins are registered from the next state so they line up with ACCESS.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    owner_nx    = owner;
    write_nx    = is_write;
    cs_nx       = 1'b0;
    we_nx       = 1'b0;
    oe_nx       = 1'b0;
    addr_nx     = sram_addr;
    wdata_nx    = sram_wdata;
    if_rdata_nx = if_rdata;
    dm_rdata_nx = dm_rdata;
    if_ready_nx = 1'b0;
    dm_ready_nx = 1'b0;
    case (state)
      IDLE: begin
        if (dm_req || if_req) begin
          state_nx = ACCESS;
          cnt_nx   = CNT_W'(WAIT_CYCLES);
          owner_nx = grant_dm;
          write_nx = grant_dm & dm_write;
          cs_nx    = 1'b1;
          we_nx    = write_nx;
          oe_nx    = ~write_nx;
          if (grant_dm) begin
            addr_nx  = dm_addr;
            wdata_nx = dm_wdata;
          end else begin
            addr_nx  = if_addr;
          end
        end
      end
      ACCESS: begin
        if (cnt == '0) begin
          state_nx = DONE;
          if (!is_write) begin
            if (owner) dm_rdata_nx = sram_rdata;
            else       if_rdata_nx = sram_rdata;
          end
          if (owner) dm_ready_nx = 1'b1;
          else       if_ready_nx = 1'b1;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
          cs_nx  = 1'b1;
          we_nx  = is_write;
          oe_nx  = ~is_write;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
